// File: rtl/csr_serial_tx.sv
// csr_serial_tx: console transmitter behind the CSR serial output port.
// Character writes are buffered in a small circular FIFO. Each accepted write
// returns a one-cycle flag-clear pulse, and each rejected write returns a
// one-cycle drop pulse. Characters leave on an 8N1 UART line, LSB first, and
// back-to-back frames are sent with no idle bit between them.
module csr_serial_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        serial_out_valid_i,
  input  logic [31:0] serial_out_data_i,
  output logic        serial_flag_clr_o,
  output logic        serial_drop_o,
  output logic        serial_full_o,
  output logic        serial_busy_o,
  output logic        tx_o
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int BW = $clog2(CLKS_PER_BIT);

  localparam logic [PW:0]   FULL_CNT  = (PW + 1)'(FIFO_DEPTH);
  localparam logic [PW:0]   CNT_ONE   = (PW + 1)'(1);
  localparam logic [PW-1:0] PTR_ONE   = PW'(1);
  localparam logic [BW-1:0] BCNT_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BCNT_ONE  = BW'(1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t        state;
  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] rptr;
  logic [PW-1:0] wptr;
  logic [PW:0]   count;
  logic [PW:0]   count_next;
  logic [BW-1:0] bcnt;
  logic [2:0]    bidx;
  logic [7:0]    shift;
  logic [7:0]    head;

  logic          bit_done;
  logic          fifo_empty;
  logic          fifo_full;
  logic          pop;
  logic          push;
  logic          to_idle;

  // Only the low byte of the written word carries the character.
  logic          data_unused;
  assign data_unused = ^serial_out_data_i[31:8];

  assign head = fifo_mem[rptr];

  // Pop, push and next-count decisions, shared by the FIFO and the line FSM.
  // A pop happens only when the shifter is loaded: in IDLE, or on the last
  // cycle of a stop bit. A push into a full FIFO is allowed when a pop frees
  // a slot in the same cycle.
  always_comb begin
    bit_done   = (bcnt == BCNT_LAST);
    fifo_empty = (count == '0);
    fifo_full  = (count == FULL_CNT);
    pop        = !fifo_empty && ((state == IDLE) || ((state == STOP) && bit_done));
    push       = serial_out_valid_i && (!fifo_full || pop);
    to_idle    = !pop && ((state == IDLE) || ((state == STOP) && bit_done));
    count_next = count;
    if (push && !pop) begin
      count_next = count + CNT_ONE;
    end else if (pop && !push) begin
      count_next = count - CNT_ONE;
    end
  end

  // Character storage. A write during reset is ignored, and the pointers are
  // cleared anyway, so stale contents are never read.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      fifo_mem[wptr] <= serial_out_data_i[7:0];
    end
  end

  // FIFO bookkeeping, handshake pulses, status flags and the UART framing FSM.
  // tx_o is registered and is loaded with the value of the bit that starts on
  // the next cycle, so every bit lasts exactly CLKS_PER_BIT cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= IDLE;
      rptr              <= '0;
      wptr              <= '0;
      count             <= '0;
      bcnt              <= '0;
      bidx              <= '0;
      shift             <= '0;
      tx_o              <= 1'b1;
      serial_flag_clr_o <= 1'b0;
      serial_drop_o     <= 1'b0;
      serial_full_o     <= 1'b0;
      serial_busy_o     <= 1'b0;
    end else begin
      count <= count_next;
      if (push) begin
        wptr <= wptr + PTR_ONE;
      end
      if (pop) begin
        rptr <= rptr + PTR_ONE;
      end
      serial_flag_clr_o <= push;
      serial_drop_o     <= serial_out_valid_i && !push;
      serial_full_o     <= (count_next == FULL_CNT);
      serial_busy_o     <= (count_next != '0) || !to_idle;

      case (state)
        IDLE: begin
          tx_o <= 1'b1;
          if (pop) begin
            shift <= head;
            bcnt  <= '0;
            tx_o  <= 1'b0;
            state <= START;
          end
        end

        START: begin
          tx_o <= 1'b0;
          if (bit_done) begin
            bcnt  <= '0;
            bidx  <= '0;
            tx_o  <= shift[0];
            state <= DATA;
          end else begin
            bcnt <= bcnt + BCNT_ONE;
          end
        end

        DATA: begin
          if (bit_done) begin
            bcnt  <= '0;
            shift <= {1'b0, shift[7:1]};
            if (bidx == 3'd7) begin
              tx_o  <= 1'b1;
              state <= STOP;
            end else begin
              bidx <= bidx + 3'd1;
              tx_o <= shift[1];
            end
          end else begin
            bcnt <= bcnt + BCNT_ONE;
          end
        end

        STOP: begin
          tx_o <= 1'b1;
          if (bit_done) begin
            bcnt <= '0;
            if (pop) begin
              shift <= head;
              tx_o  <= 1'b0;
              state <= START;
            end else begin
              state <= IDLE;
            end
          end else begin
            bcnt <= bcnt + BCNT_ONE;
          end
        end

        default: begin
          tx_o  <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_csr_serial_tx.sv
// Testbench for csr_serial_tx. A frame-level reference model predicts the
// handshake pulses, the status flags and the line level for each cycle, and it
// queues the expected characters. A UART receiver process decodes tx and
// checks each frame against that queue.
module tb_csr_serial_tx;

  localparam int C = 4;
  localparam int D = 4;

  logic        clk;
  logic        rst;
  logic        serial_out_valid_i;
  logic [31:0] serial_out_data_i;
  logic        serial_flag_clr_o;
  logic        serial_drop_o;
  logic        serial_full_o;
  logic        serial_busy_o;
  logic        tx_o;

  csr_serial_tx #(
    .CLKS_PER_BIT(C),
    .FIFO_DEPTH  (D)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .serial_out_valid_i(serial_out_valid_i),
    .serial_out_data_i (serial_out_data_i),
    .serial_flag_clr_o (serial_flag_clr_o),
    .serial_drop_o     (serial_drop_o),
    .serial_full_o     (serial_full_o),
    .serial_busy_o     (serial_busy_o),
    .tx_o              (tx_o)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state
  int         cyc          = 0;
  bit         chk_en       = 0;
  int         reset_gen    = 0;
  logic [7:0] m_fifo[$];
  logic [7:0] sb_q[$];
  int         start_q[$];
  int         m_frame_start = 0;
  int         m_frame_end   = -1;
  logic [7:0] cur_char      = 8'h00;
  logic       exp_tx, exp_flag, exp_drop, exp_full, exp_busy;

  // Receiver state
  int         mon_gen   = 0;
  bit         rx_active = 0;
  int         rx_off    = 0;
  int         rx_start  = 0;
  logic [7:0] rx_byte   = 8'h00;

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Absolute time limit.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic line_at(input int t);
    int off;
    if (t < m_frame_start || t > m_frame_end) return 1'b1;
    off = (t - m_frame_start) / C;
    if (off == 0) return 1'b0;
    if (off == 9) return 1'b1;
    return cur_char[off-1];
  endfunction

  // Reference model: advances one cycle on every rising edge, using the inputs
  // that were held during the cycle that is ending.
  always @(posedge clk) begin
    bit  pop;
    bit  acc;
    if (rst) begin
      m_fifo.delete();
      sb_q.delete();
      start_q.delete();
      m_frame_end = -1;
      reset_gen++;
      chk_en   = 1;
      exp_tx   = 1'b1;
      exp_flag = 1'b0;
      exp_drop = 1'b0;
      exp_full = 1'b0;
      exp_busy = 1'b0;
    end else begin
      pop = (m_fifo.size() > 0) && (cyc >= m_frame_end);
      if (pop) begin
        cur_char      = m_fifo.pop_front();
        m_frame_start = cyc + 1;
        m_frame_end   = cyc + 10 * C;
        start_q.push_back(cyc + 1);
      end
      acc = serial_out_valid_i && ((m_fifo.size() < D) || pop);
      if (acc) begin
        m_fifo.push_back(serial_out_data_i[7:0]);
        sb_q.push_back(serial_out_data_i[7:0]);
      end
      exp_flag = acc;
      exp_drop = serial_out_valid_i && !acc;
      exp_full = (m_fifo.size() == D);
      exp_busy = (m_fifo.size() > 0) || (cyc + 1 <= m_frame_end);
      exp_tx   = line_at(cyc + 1);
    end
    cyc++;
  end

  // Per-cycle output comparison plus a UART receiver that pops the
  // scoreboard for every decoded frame.
  always @(negedge clk) begin
    if (chk_en) begin
      checkOutput("tx", tx_o, exp_tx);
      checkOutput("flag_clr", serial_flag_clr_o, exp_flag);
      checkOutput("drop", serial_drop_o, exp_drop);
      checkOutput("full", serial_full_o, exp_full);
      checkOutput("busy", serial_busy_o, exp_busy);

      if (mon_gen != reset_gen) begin
        mon_gen   = reset_gen;
        rx_active = 0;
      end
      if (!rx_active) begin
        if (tx_o === 1'b0) begin
          rx_active = 1;
          rx_off    = 0;
          rx_start  = cyc;
        end
      end else begin
        rx_off++;
      end
      if (rx_active) begin
        if (rx_off == C / 2) begin
          checkOutput("start_bit", tx_o, 1'b0);
        end
        for (int k = 0; k < 8; k++) begin
          if (rx_off == C * (k + 1) + C / 2) rx_byte[k] = tx_o;
        end
        if (rx_off == 9 * C + C / 2) begin
          rx_active = 0;
          checkOutput("stop_bit", tx_o, 1'b1);
          if (sb_q.size() == 0) begin
            checkOutput("unexpected_frame", {24'h0, rx_byte}, 32'hFFFF_FFFF);
          end else begin
            checkOutput("rx_char", rx_byte, sb_q.pop_front());
            if (start_q.size() != 0) begin
              checkOutput("frame_start", rx_start, start_q.pop_front());
            end else begin
              checkOutput("frame_start_missing", rx_start, 32'hFFFF_FFFF);
            end
          end
        end
      end
    end
  end

  task automatic applyStimulus(input logic [31:0] d);
    serial_out_valid_i = 1'b1;
    serial_out_data_i  = d;
    @(negedge clk);
    serial_out_valid_i = 1'b0;
    serial_out_data_i  = $urandom;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drain(input int limit);
    int n = 0;
    while ((sb_q.size() != 0 || cyc <= m_frame_end + 2) && n < limit) begin
      @(negedge clk);
      n++;
    end
    checkOutput("drain_pending", sb_q.size(), 0);
  endtask

  initial begin
    int n;
    rst                = 1'b1;
    serial_out_valid_i = 1'b0;
    serial_out_data_i  = 32'h0;
    idle(3);
    rst = 1'b0;
    idle(7);

    // Single character
    applyStimulus(32'h1234_5641);
    drain(200);

    // Back-to-back pair
    applyStimulus(32'h55);
    applyStimulus(32'hAA);
    drain(300);

    // Overflow: six consecutive writes, the last one dropped
    for (int i = 0; i < 6; i++) applyStimulus($urandom);
    drain(600);

    // Push while full in the final stop-bit cycle
    for (int i = 0; i < 5; i++) applyStimulus($urandom);
    n = 0;
    while (!(cyc == m_frame_end && m_fifo.size() == D) && n < 200) begin
      @(negedge clk);
      n++;
    end
    checkOutput("wait_stop_final", n < 200, 1'b1);
    applyStimulus(32'hC3);
    drain(600);

    // Reset during data bit 3 with two entries queued
    for (int i = 0; i < 3; i++) applyStimulus($urandom);
    n = 0;
    while (!(cyc == m_frame_start + 4 * C + 1 && m_fifo.size() == 2) && n < 200) begin
      @(negedge clk);
      n++;
    end
    checkOutput("wait_data_bit3", n < 200, 1'b1);
    rst                = 1'b1;
    serial_out_valid_i = 1'b1;
    serial_out_data_i  = 32'hEE;
    @(negedge clk);
    rst                = 1'b0;
    serial_out_valid_i = 1'b0;
    idle(100);
    applyStimulus(32'h33);
    drain(200);

    // Pointer wrap with gaps wide enough that the FIFO never fills
    for (int i = 0; i < 3 * D; i++) begin
      applyStimulus($urandom);
      idle($urandom_range(35, 60));
    end
    drain(800);

    // Random traffic
    for (int i = 0; i < 40; i++) begin
      applyStimulus($urandom);
      idle($urandom_range(0, 25));
    end
    drain(3000);

    idle(5);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/csr_serial_tx.md
# csr_serial_tx

Console transmitter at the far end of the CSR file's serial output port. It accepts one-cycle character writes (`serial_out_valid` / `serial_out_data`) and buffers them in a small FIFO. It returns a one-cycle flag-clear pulse to the CSR file and serializes each character onto an 8N1 UART line. It sits beside the CSR unit in the core top level and drives the board/simulation console pin.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 16: clock cycles per UART bit. Legal values are ≥ 2.
- `FIFO_DEPTH`, default 4: number of character entries. Must be a power of 2 and ≥ 2.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `serial_out_valid_i`  in  1  one-cycle write strobe from the CSR file.
- `serial_out_data_i`  in  32  written word. Only `[7:0]` (the character) is used; `[31:8]` is ignored.
- `serial_flag_clr_o`  out  1  one-cycle pulse, the cycle after a write is accepted. It clears the CSR pending flag.
- `serial_drop_o`  out  1  one-cycle pulse, the cycle after a write is rejected because the FIFO is full.
- `serial_full_o`  out  1  FIFO count == FIFO_DEPTH (registered).
- `serial_busy_o`  out  1  FIFO non-empty, or FSM not in IDLE (registered).
- `tx_o`  out  1  UART line. Idles high; registered.

## Operation
FIFO:
- Circular buffer with `$clog2(FIFO_DEPTH)`-bit read/write pointers that wrap modulo FIFO_DEPTH.
- Separate count register, `$clog2(FIFO_DEPTH)+1` bits wide.
- Write acceptance: a write is accepted when `serial_out_valid_i && (!full || pop_this_cycle)`.
- Simultaneous push and pop: count is unchanged and both pointers advance.
- Rejected write (valid while full with no pop): data is discarded, pointers and count are unchanged, and `serial_drop_o` pulses.
- Pop happens only when the FSM loads the shifter; it is never issued when empty.

FSM states: IDLE, START, DATA, STOP.
- Baud counter `bcnt` counts 0..CLKS_PER_BIT-1. Bit index `bidx` is 3 bits, 0..7.
- IDLE: `tx_o`=1. If FIFO is non-empty, pop the head into an 8-bit shift register, set bcnt=0, and go to START.
- START: `tx_o`=0 for CLKS_PER_BIT cycles. When bcnt==CLKS_PER_BIT-1, set bcnt=0, bidx=0, and go to DATA.
- DATA: `tx_o`=shift[0]. LSB is sent first.
  - On bcnt==CLKS_PER_BIT-1, shift right.
  - If bidx==7, go to STOP; otherwise increment bidx.
- STOP: `tx_o`=1 for CLKS_PER_BIT cycles. On the final cycle:
  - if FIFO is non-empty, pop and go directly to START (back-to-back frames, no extra idle bit);
  - otherwise go to IDLE.
- Frame length is exactly 10·CLKS_PER_BIT cycles.
- `serial_busy_o` / `serial_full_o` reflect the post-edge count and state.

Reset:
- Values while `rst`=1: `tx_o`=1, `serial_flag_clr_o`=0, `serial_drop_o`=0, `serial_full_o`=0, `serial_busy_o`=0.
- Reset state: FSM=IDLE, pointers/count/bcnt/bidx=0, shift=0.
- Reset mid-frame abandons the frame and all buffered characters. `tx_o` is high from the first cycle after the reset edge.
- A write presented in the same cycle as `rst` is ignored.

## Timing
- Write in cycle N:
  - entry is visible (count incremented) in N+1;
  - `serial_flag_clr_o` is high in N+1 only;
  - or, if rejected, `serial_drop_o` is high in N+1 only.
- FSM in IDLE with an empty FIFO at cycle N: pop at the end of N+1, and `tx_o` falls at cycle N+2 (start bit).
- Bit k of the character (k=0..7) occupies `tx_o` for cycles [N+2+(k+1)·CLKS_PER_BIT, N+2+(k+2)·CLKS_PER_BIT).
- Stop bit ends at N+2+10·CLKS_PER_BIT. `serial_busy_o` falls in that cycle if nothing is queued.
- Back-to-back frames: the next start bit begins the cycle immediately after the last stop-bit cycle.
- No combinational path from inputs to any output.

## Test plan
- Single character, CLKS_PER_BIT=4: write 0x12345641 at cycle 10 (after reset).
  - `serial_flag_clr_o`=1 at cycle 11 only.
  - `tx_o` is 1 through cycle 11, 0 for cycles 12–15.
  - Data bits 1,0,0,0,0,0,1,0 (0x41 LSB-first), 4 cycles each, over cycles 16–47.
  - Stop bit 1 over cycles 48–51; `serial_busy_o`=0 from cycle 52.
- Back-to-back: write 0x55 then 0xAA on consecutive cycles.
  - Two flag-clr pulses; no drop.
  - Second start bit begins exactly 10·CLKS_PER_BIT cycles after the first.
  - Line never idles between the frames.
- Overflow, FIFO_DEPTH=4: six writes on consecutive cycles 0–5.
  - Writes 0–4 accepted (one popped into the shifter at cycle 1, four buffered).
  - `serial_full_o`=1 at cycle 5.
  - Write 5 is dropped: `serial_drop_o`=1 at cycle 6, no flag-clr at cycle 6.
  - Exactly 5 frames are transmitted, in write order.
- Push on full with simultaneous pop: fill the FIFO during a frame, then write exactly in the STOP final cycle.
  - Write is accepted (flag-clr, no drop).
  - Count stays 4; pointers wrap correctly.
  - All characters are emitted in order.
- Reset mid-frame: assert `rst` for 1 cycle during DATA bit 3 with 2 entries queued.
  - `tx_o`=1 from the next cycle; `serial_busy_o`=0; `serial_full_o`=0.
  - No further frames.
  - A subsequent write of 0x33 transmits normally.
- Pointer wrap: 3·FIFO_DEPTH characters written with gaps so the FIFO never fills.
  - All characters are received in order; zero drops.
